// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit with HI/LO registers and multi-cycle busy window
// Optional madd/maddu/msub/msubu support is enabled by defining MD_UNIT_MADD_EN.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  pend_hi, pend_lo;
    logic              pend_wr;

    logic              accept, is_mul, is_div, is_long, div_signed;
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic [WIDTH-1:0]  a_mag, b_mag, num, den, q_mag, r_mag, quo, rem;
    logic [WIDTH-1:0]  res_hi, res_lo;
    logic              res_wr;
`ifdef MD_UNIT_MADD_EN
    logic [2*WIDTH-1:0] acc_base;
`endif

    always_comb begin
        is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MD_UNIT_MADD_EN
        is_mul = is_mul || (md_op == OP_MADD) || (md_op == OP_MADDU)
                        || (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
        is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
        is_long = is_mul || is_div;
        accept  = start && (state_q == IDLE);
    end

    // Low 2*WIDTH bits of an unsigned product of sign-extended operands equal the signed product.
    always_comb begin
        a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
        b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
        a_zx   = {{WIDTH{1'b0}}, A};
        b_zx   = {{WIDTH{1'b0}}, B};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;
    end

    // Signed division works on magnitudes; most-negative / -1 falls out as 0x80.. with remainder 0.
    always_comb begin
        div_signed = (md_op == OP_DIV);
        a_mag = A[WIDTH-1] ? -A : A;
        b_mag = B[WIDTH-1] ? -B : B;
        num   = div_signed ? a_mag : A;
        den   = div_signed ? b_mag : B;
        if (den == '0)
            den = {{(WIDTH-1){1'b0}}, 1'b1};
        q_mag = num / den;
        r_mag = num % den;
        quo   = (div_signed && (A[WIDTH-1] ^ B[WIDTH-1])) ? -q_mag : q_mag;
        rem   = (div_signed && A[WIDTH-1]) ? -r_mag : r_mag;
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b1;
`ifdef MD_UNIT_MADD_EN
        acc_base = {hi, lo};
`endif
        case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quo;
                res_wr = (B != '0);
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD:  {res_hi, res_lo} = acc_base + prod_s;
            OP_MADDU: {res_hi, res_lo} = acc_base + prod_u;
            OP_MSUB:  {res_hi, res_lo} = acc_base - prod_s;
            OP_MSUBU: {res_hi, res_lo} = acc_base - prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && is_long) state_d = RUN;
            RUN:  if (cnt == CNT_ONE)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (accept) begin
            if (is_long) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
                cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
            end else if (md_op == OP_MTHI) begin
                hi <= A;
            end else if (md_op == OP_MTLO) begin
                lo <= A;
            end
        end else if (state_q == RUN) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                pend_wr <= 1'b0;
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end

endmodule
